// File: rtl/vehicle_gate_pkg.sv
// Shared types and default constants for the vehicle gate controller.
// Cycle counts are derived from the 50 MHz system clock.
package vehicle_gate_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int WIDTH_SPEED_DEF = 14;
  localparam int SPEED_LIMIT_DEF = 40;
  localparam int MAX_VEH_DEF     = 3;
  localparam int MIN_CYC_DEF     = CLK_HZ / 1000;
  localparam int TIMEOUT_CYC_DEF = CLK_HZ / 2;
  localparam int HOLD_CYC_DEF    = 3 * CLK_HZ;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TIMING,
    S_CALC,
    S_WAIT_DONE,
    S_DECIDE,
    S_OPEN
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus rising-edge detect; rise is combinational off the
// synchronized level, so pin-to-rise is two clocks and the consumer registers it.
module edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh <= '0;
    end else begin
      sh <= {sh[1:0], async_in};
    end
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/vehicle_gate_ctrl.sv
// Sequences the speed/occupancy datapath from beam sensors and decides barrier opening.
// Sensor pin to strobe is three clocks; all outputs registered, no backpressure (done is awaited).
module vehicle_gate_ctrl
  import vehicle_gate_pkg::*;
#(
  parameter int WIDTH_SPEED = WIDTH_SPEED_DEF,
  parameter int SPEED_LIMIT = SPEED_LIMIT_DEF,
  parameter int MAX_VEH     = MAX_VEH_DEF,
  parameter int MIN_CYC     = MIN_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int HOLD_CYC    = HOLD_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sen1_in,
  input  logic                   sen2_in,
  input  logic                   exit_in,
  input  logic                   man_open,
  input  logic                   done,
  input  logic [1:0]             num_veh,
  input  logic [WIDTH_SPEED-1:0] speed,
  output logic                   init,
  output logic                   count,
  output logic                   cal,
  output logic                   up,
  output logic                   down,
  output logic                   en,
  output logic                   dis,
  output logic [WIDTH_SPEED-1:0] speed_q,
  output logic                   overspeed,
  output logic                   full,
  output logic                   err,
  output logic                   busy
);

  localparam int TMAX = max_int(TIMEOUT_CYC, HOLD_CYC);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]          T_SAT     = TW'(TMAX);
  localparam logic [TW-1:0]          T_MIN     = TW'(MIN_CYC);
  localparam logic [TW-1:0]          T_TIMEOUT = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0]          T_HOLD    = TW'(HOLD_CYC);
  localparam logic [WIDTH_SPEED-1:0] LIMIT     = WIDTH_SPEED'(SPEED_LIMIT);

  logic sen1_p, sen2_p, exit_p, man_p;

  edge_sync u_sen1 (.clk(clk), .reset_n(reset_n), .async_in(sen1_in),  .rise(sen1_p));
  edge_sync u_sen2 (.clk(clk), .reset_n(reset_n), .async_in(sen2_in),  .rise(sen2_p));
  edge_sync u_exit (.clk(clk), .reset_n(reset_n), .async_in(exit_in),  .rise(exit_p));
  edge_sync u_man  (.clk(clk), .reset_n(reset_n), .async_in(man_open), .rise(man_p));

  state_t        state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;

  // One timer serves both the sen1->sen2 measurement and the barrier hold; it saturates.
  assign timer_inc = (timer == T_SAT) ? timer : timer + 1'b1;

  // Outputs are registered, so each transition also loads the level outputs of its target state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      init      <= 1'b0;
      count     <= 1'b0;
      cal       <= 1'b0;
      up        <= 1'b0;
      down      <= 1'b0;
      en        <= 1'b0;
      dis       <= 1'b0;
      speed_q   <= '0;
      overspeed <= 1'b0;
      full      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cal  <= 1'b0;
      up   <= 1'b0;
      dis  <= 1'b0;
      down <= exit_p && (num_veh != 2'd0);
      en   <= man_p;

      case (state)
        S_IDLE: begin
          if (sen1_p) begin
            state     <= S_TIMING;
            timer     <= '0;
            overspeed <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
            init      <= 1'b0;
            count     <= 1'b1;
            busy      <= 1'b1;
          end else begin
            init  <= 1'b1;
            count <= 1'b0;
            busy  <= 1'b0;
          end
        end

        S_TIMING: begin
          timer <= timer_inc;
          if (sen2_p && (timer < T_MIN)) begin
            state <= S_IDLE;
            err   <= 1'b1;
            count <= 1'b0;
            init  <= 1'b1;
            busy  <= 1'b0;
          end else if (sen2_p) begin
            state <= S_CALC;
            count <= 1'b0;
            cal   <= 1'b1;
          end else if (timer_inc >= T_TIMEOUT) begin
            state <= S_IDLE;
            err   <= 1'b1;
            count <= 1'b0;
            init  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        S_CALC: state <= S_WAIT_DONE;

        S_WAIT_DONE: begin
          if (done) begin
            speed_q <= speed;
            state   <= S_DECIDE;
          end
        end

        S_DECIDE: begin
          if (speed_q > LIMIT) begin
            overspeed <= 1'b1;
            state     <= S_IDLE;
            init      <= 1'b1;
            busy      <= 1'b0;
          end else if (int'(num_veh) >= MAX_VEH) begin
            full  <= 1'b1;
            state <= S_IDLE;
            init  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            up    <= 1'b1;
            timer <= '0;
            state <= S_OPEN;
          end
        end

        S_OPEN: begin
          timer <= timer_inc;
          if (timer_inc >= T_HOLD) begin
            dis   <= 1'b1;
            state <= S_IDLE;
            init  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          init  <= 1'b1;
          count <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
